// File: rtl/adder_error_monitor_if.sv
// Operand/result tap between the adder under evaluation and its error monitor.
// master drives the operand set and the adder's answer; slave returns in_ready.
interface adder_error_monitor_if #(
  parameter int WIDTH = 8
);
  // A set transfers on a rising edge where in_valid && in_ready. in_valid may
  // be raised without waiting for in_ready; a set offered while in_ready is low
  // is simply not taken (the monitor has no input buffer).
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic [WIDTH-1:0] dut_sum;
  logic             dut_c_out;

  modport master (
    output in_valid, a, b, c_in, dut_sum, dut_c_out,
    input  in_ready
  );

  modport slave (
    input  in_valid, a, b, c_in, dut_sum, dut_c_out,
    output in_ready
  );
endinterface

// File: rtl/adder_error_monitor.sv
// Windowed error statistics for an approximate adder: count, max and sum of |error|.
// Define ERRMON_SQERR_EN to add the saturating sum_sq_err accumulator and port.
module adder_error_monitor #(
    parameter int WIDTH   = 8,
    parameter int SAMPLES = 16,
    parameter int ACC_W   = 16,
    parameter int SQ_W    = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    adder_error_monitor_if.slave         bus,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(SAMPLES+1)-1:0] err_count,
    output logic [WIDTH:0]               max_err,
    output logic [ACC_W-1:0]             sum_abs_err,
    output logic                         sat,
`ifdef ERRMON_SQERR_EN
    output logic [SQ_W-1:0]              sum_sq_err,
`endif
    output logic [1:0]                   state_dbg
);

    localparam int CNT_W = $clog2(SAMPLES + 1);
    localparam int RW    = WIDTH + 1;
    localparam int AW1   = ACC_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  acc_cnt;
    logic              accept, last_accept, clear;
    logic              s1_valid, s2_valid;
    logic [RW-1:0]     s1_exact, s1_dut, s2_err, err_abs;
    logic [AW1-1:0]    abs_sum_ext;
    logic              abs_ovf;

    assign bus.in_ready = (state == RUN) && (acc_cnt < CNT_W'(SAMPLES));
    assign accept       = bus.in_valid && bus.in_ready;
    assign last_accept  = accept && (acc_cnt == CNT_W'(SAMPLES - 1));
    assign clear        = start && ((state == IDLE) || (state == DONE));

    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);
    assign state_dbg = state;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_accept) state_nx = DRAIN;
            // Stage 1 empty means stage 2 retires its last sample on this edge.
            DRAIN:   if (!s1_valid) state_nx = DONE;
            DONE:    if (start) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) acc_cnt <= '0;
        else if (accept)  acc_cnt <= acc_cnt + CNT_W'(1);
    end

    // Stage 1: exact reference and the adder's answer, captured on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_exact <= '0;
            s1_dut   <= '0;
        end else begin
            s1_valid <= accept;
            s1_exact <= RW'(bus.a) + RW'(bus.b) + RW'(bus.c_in);
            s1_dut   <= {bus.dut_c_out, bus.dut_sum};
        end
    end

    assign err_abs = (s1_exact >= s1_dut) ? (s1_exact - s1_dut) : (s1_dut - s1_exact);

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_err   <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_err   <= err_abs;
        end
    end

    assign abs_sum_ext = {1'b0, sum_abs_err} + AW1'(s2_err);
    assign abs_ovf     = abs_sum_ext[ACC_W];

`ifdef ERRMON_SQERR_EN
    localparam int PW    = 2 * RW;
    localparam int SQX_W = ((SQ_W > PW) ? SQ_W : PW) + 1;
    logic [PW-1:0]    err_sq;
    logic [SQX_W-1:0] sq_sum_ext;
    logic             sq_ovf;

    assign err_sq     = PW'(s2_err) * PW'(s2_err);
    assign sq_sum_ext = SQX_W'(sum_sq_err) + SQX_W'(err_sq);
    assign sq_ovf     = |sq_sum_ext[SQX_W-1:SQ_W];

    always_ff @(posedge clk) begin
        if (rst || clear)  sum_sq_err <= '0;
        else if (s2_valid) sum_sq_err <= sq_ovf ? {SQ_W{1'b1}} : sq_sum_ext[SQ_W-1:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            err_count   <= '0;
            max_err     <= '0;
            sum_abs_err <= '0;
            sat         <= 1'b0;
        end else if (s2_valid) begin
            if (s2_err != '0)     err_count <= err_count + CNT_W'(1);
            if (s2_err > max_err) max_err   <= s2_err;
            sum_abs_err <= abs_ovf ? {ACC_W{1'b1}} : abs_sum_ext[ACC_W-1:0];
`ifdef ERRMON_SQERR_EN
            if (abs_ovf || sq_ovf) sat <= 1'b1;
`else
            if (abs_ovf) sat <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_adder_error_monitor.sv
// Directed bench for adder_error_monitor: table of measurement windows plus
// hand sequences for gapped valid, mid-run reset and accumulator saturation.
module tb_adder_error_monitor;
  localparam int WIDTH   = 8;
  localparam int SAMPLES = 4;
  localparam int CNT_W   = $clog2(SAMPLES + 1);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic [8:0] dut;
  } smp_t;

  typedef struct {
    int unsigned cnt;
    int unsigned max;
    int unsigned sum;
    int unsigned sq;
    int unsigned sat;
  } win_t;

  logic clk = 1'b0;
  logic rst;
  logic start;

  logic             busy1, done1, sat1, busy2, done2, sat2;
  logic [CNT_W-1:0] err_count1, err_count2;
  logic [WIDTH:0]   max_err1, max_err2;
  logic [15:0]      sum_abs1;
  logic [9:0]       sum_abs2;
  logic [1:0]       st1, st2;
`ifdef ERRMON_SQERR_EN
  logic [23:0]      sq1, sq2;
`endif

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_q[$];

  smp_t vec[16];
  win_t win[4];

  adder_error_monitor_if #(.WIDTH(WIDTH)) bus1 ();
  adder_error_monitor_if #(.WIDTH(WIDTH)) bus2 ();

  // Second monitor sees the same traffic but has a narrow accumulator.
  assign bus2.in_valid  = bus1.in_valid;
  assign bus2.a         = bus1.a;
  assign bus2.b         = bus1.b;
  assign bus2.c_in      = bus1.c_in;
  assign bus2.dut_sum   = bus1.dut_sum;
  assign bus2.dut_c_out = bus1.dut_c_out;

  adder_error_monitor #(.WIDTH(WIDTH), .SAMPLES(SAMPLES), .ACC_W(16), .SQ_W(24)) dut1 (
    .clk(clk), .rst(rst), .start(start), .bus(bus1),
    .busy(busy1), .done(done1), .err_count(err_count1), .max_err(max_err1),
    .sum_abs_err(sum_abs1), .sat(sat1),
`ifdef ERRMON_SQERR_EN
    .sum_sq_err(sq1),
`endif
    .state_dbg(st1)
  );

  adder_error_monitor #(.WIDTH(WIDTH), .SAMPLES(SAMPLES), .ACC_W(10), .SQ_W(24)) dut2 (
    .clk(clk), .rst(rst), .start(start), .bus(bus2),
    .busy(busy2), .done(done2), .err_count(err_count2), .max_err(max_err2),
    .sum_abs_err(sum_abs2), .sat(sat2),
`ifdef ERRMON_SQERR_EN
    .sum_sq_err(sq2),
`endif
    .state_dbg(st2)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Scoreboard helpers
  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_err_count"}, err_count1, 0);
    check({tag, "_max_err"}, max_err1, 0);
    check({tag, "_sum_abs"}, sum_abs1, 0);
    check({tag, "_sat"}, sat1, 0);
    check({tag, "_busy"}, busy1, 0);
    check({tag, "_done"}, done1, 0);
    check({tag, "_in_ready"}, bus1.in_ready, 0);
    check({tag, "_state"}, st1, ST_IDLE);
`ifdef ERRMON_SQERR_EN
    check({tag, "_sum_sq"}, sq1, 0);
`endif
  endtask

  // Driver tasks; all entered and left at a falling edge.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive(input smp_t s, input logic v);
    bus1.in_valid  = v;
    bus1.a         = s.a;
    bus1.b         = s.b;
    bus1.c_in      = s.c_in;
    bus1.dut_sum   = s.dut[7:0];
    bus1.dut_c_out = s.dut[8];
  endtask

  task automatic send(input smp_t s);
    int guard;
    guard = 0;
    drive(s, 1'b1);
    while (!bus1.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("send_ready_timeout", 0, 1);
    @(negedge clk);
    bus1.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (!done1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_latency"}, n, exp_cycles);
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_err_count"}, err_count1, exp_q.pop_front());
    check({tag, "_max_err"}, max_err1, exp_q.pop_front());
    check({tag, "_sum_abs"}, sum_abs1, exp_q.pop_front());
    check({tag, "_sat"}, sat1, exp_q.pop_front());
`ifdef ERRMON_SQERR_EN
    check({tag, "_sum_sq"}, sq1, exp_q.pop_front());
`else
    void'(exp_q.pop_front());
`endif
  endtask

  task automatic run_window(input int w);
    string tag;
    tag = $sformatf("win%0d", w);
    exp_q.push_back(win[w].cnt);
    exp_q.push_back(win[w].max);
    exp_q.push_back(win[w].sum);
    exp_q.push_back(win[w].sat);
    exp_q.push_back(win[w].sq);
    do_start();
    check({tag, "_busy_run"}, busy1, 1);
    for (int i = 0; i < SAMPLES; i++) send(vec[w*4 + i]);
    check({tag, "_done_early"}, done1, 0);
    check({tag, "_ready_drain"}, bus1.in_ready, 0);
    wait_done(tag, 2);
    check({tag, "_busy_done"}, busy1, 0);
    check_stats(tag);
  endtask

  initial begin
    // Window table: exact adder, constant 256 error, mixed +1/0/-3/+2, error 511.
    vec[0]  = '{8'd12,  8'd34,  1'b0, 9'd46};
    vec[1]  = '{8'd255, 8'd255, 1'b1, 9'd511};
    vec[2]  = '{8'd128, 8'd128, 1'b0, 9'd256};
    vec[3]  = '{8'd7,   8'd0,   1'b1, 9'd8};
    for (int i = 4; i < 8; i++) vec[i] = '{8'd200, 8'd100, 1'b1, 9'h02D};
    vec[8]  = '{8'd10, 8'd5, 1'b0, 9'd16};
    vec[9]  = '{8'd10, 8'd5, 1'b0, 9'd15};
    vec[10] = '{8'd10, 8'd5, 1'b0, 9'd12};
    vec[11] = '{8'd10, 8'd5, 1'b0, 9'd17};
    for (int i = 12; i < 16; i++) vec[i] = '{8'd0, 8'd0, 1'b0, 9'd511};
    win[0] = '{0, 0,   0,    0,       0};
    win[1] = '{4, 256, 1024, 262144,  0};
    win[2] = '{3, 3,   6,    14,      0};
    win[3] = '{4, 511, 2044, 1044484, 0};

    rst   = 1'b1;
    start = 1'b0;
    drive('{8'd0, 8'd0, 1'b0, 9'd0}, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_outputs_zero("reset");

    run_window(0);
    run_window(1);
    run_window(2);

    // Gapped valid: 1,0,1,1,0,1 after the start cycle, each set off by +1.
    begin
      logic [5:0] pat;
      pat = 6'b101101;
      do_start();
      for (int i = 0; i < 6; i++) begin
        drive(vec[8], pat[5 - i]);
        @(negedge clk);
      end
      for (int i = 0; i < 3; i++) begin
        check($sformatf("gap_ready_after_%0d", i), bus1.in_ready, 0);
        @(negedge clk);
      end
      check("gap_done", done1, 1);
      check("gap_err_count", err_count1, 4);
      check("gap_sum_abs", sum_abs1, 4);
      check("gap_max_err", max_err1, 1);
      bus1.in_valid = 1'b0;
    end

    // Reset with two error samples in flight.
    do_start();
    send(vec[4]);
    send(vec[5]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_outputs_zero("midrst");
    repeat (2) @(negedge clk);
    check_outputs_zero("midrst_later");
    run_window(2);

    // Narrow accumulator saturates; wide one does not.
    run_window(3);
    check("sat_sum_abs_narrow", sum_abs2, 1023);
    check("sat_flag_narrow", sat2, 1);
    check("sat_max_err_narrow", max_err2, 511);
    repeat (3) @(negedge clk);
    check("done_hold_sum", sum_abs1, 2044);
    check("done_hold_sat_narrow", sat2, 1);
    do_start();
    check("restart_sat_clear", sat2, 0);
    check("restart_sum_clear", sum_abs2, 0);
    check("restart_done_drop", done1, 0);
    check("restart_state_run", st1, ST_RUN);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
